// File: rtl/bf_io_responder.sv
// Byte I/O responder for the CPU's '.' and ',' instructions.
// CPU writes queue into a TX FIFO that drains to a valid/ready byte sink.
// CPU reads pop from an RX FIFO that is filled from a valid/ready byte source.
// A read on an empty RX FIFO blocks until a byte arrives.

// Small byte FIFO with first-word fall-through head and an occupancy count.
// Push when full and pop when empty are ignored, so the level cannot wrap.
module bf_io_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage has no reset; only pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; a simultaneous push and pop keeps the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
    end
  end

endmodule

// Top level: four-phase CPU handshake in front of the two FIFOs.
module bf_io_responder #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               io_req,
  input  logic               io_dir,
  input  logic [7:0]         io_wdata,
  output logic               io_ack,
  output logic [7:0]         io_rdata,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic [FIFO_AW:0]   tx_level,
  output logic [FIFO_AW:0]   rx_level,
  output logic               rd_blocked
);

  localparam logic DIRECTION_READ  = 1'b0;
  localparam logic DIRECTION_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        ack_next;
  logic        blocked_next;
  logic        load_rdata;
  logic        tx_push;
  logic        tx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic        rx_push;
  logic        rx_pop;
  logic        rx_full;
  logic        rx_empty;
  logic [7:0]  rx_head;

  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;

  bf_io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (io_wdata),
    .pop       (tx_pop),
    .head      (tx_data),
    .level     (tx_level),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  bf_io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .level     (rx_level),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Next-state logic; full/empty come from pre-edge levels, so a same-edge
  // drain or fill never lets a waiting request through early.
  always_comb begin
    state_next   = state;
    ack_next     = io_ack;
    blocked_next = rd_blocked;
    load_rdata   = 1'b0;
    tx_push      = 1'b0;
    rx_pop       = 1'b0;
    case (state)
      IDLE: begin
        if (io_req) begin
          if (io_dir == DIRECTION_WRITE) begin
            if (!tx_full) begin
              tx_push    = 1'b1;
              ack_next   = 1'b1;
              state_next = ACK;
            end else begin
              state_next = WR_WAIT;
            end
          end else if (io_dir == DIRECTION_READ) begin
            if (!rx_empty) begin
              rx_pop     = 1'b1;
              load_rdata = 1'b1;
              ack_next   = 1'b1;
              state_next = ACK;
            end else begin
              blocked_next = 1'b1;
              state_next   = RD_WAIT;
            end
          end
        end
      end
      WR_WAIT: begin
        if (!tx_full) begin
          tx_push    = 1'b1;
          ack_next   = 1'b1;
          state_next = ACK;
        end
      end
      RD_WAIT: begin
        if (!rx_empty) begin
          rx_pop       = 1'b1;
          load_rdata   = 1'b1;
          ack_next     = 1'b1;
          blocked_next = 1'b0;
          state_next   = ACK;
        end
      end
      ACK: begin
        if (!io_req) begin
          ack_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered handshake outputs; io_rdata only changes on a successful pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      io_ack     <= 1'b0;
      rd_blocked <= 1'b0;
      io_rdata   <= 8'h00;
    end else begin
      state      <= state_next;
      io_ack     <= ack_next;
      rd_blocked <= blocked_next;
      if (load_rdata) begin
        io_rdata <= rx_head;
      end
    end
  end

endmodule

// File: tb/tb_bf_io_responder.sv
// Self-checking bench for bf_io_responder, using queue-based expectations.
module tb_bf_io_responder;

  localparam int DEPTH = 16;
  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       io_req = 1'b0;
  logic       io_dir = 1'b0;
  logic [7:0] io_wdata = 8'h00;
  logic       io_ack;
  logic [7:0] io_rdata;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready;
  logic [4:0] tx_level;
  logic [4:0] rx_level;
  logic       rd_blocked;

  int total = 0;
  int bad = 0;
  logic [7:0] last_rd = 8'h00;

  bf_io_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .io_req     (io_req),
    .io_dir     (io_dir),
    .io_wdata   (io_wdata),
    .io_ack     (io_ack),
    .io_rdata   (io_rdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_level   (tx_level),
    .rx_level   (rx_level),
    .rd_blocked (rd_blocked)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] aborting");
  end

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // CPU write with bounded waits for ack rise and fall.
  task automatic cpu_write(input logic [7:0] d, output bit ok);
    bit seen = 0;
    io_req = 1'b1; io_dir = DIR_WR; io_wdata = d;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (io_ack) seen = 1;
    end
    io_req = 1'b0;
    ok = seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (!io_ack) seen = 1;
    end
    ok = ok && seen;
  endtask

  // CPU read with bounded waits; returns the byte seen while ack is high.
  task automatic cpu_read(output logic [7:0] d, output bit ok);
    bit seen = 0;
    d = 8'hxx;
    io_req = 1'b1; io_dir = DIR_RD;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (io_ack) begin seen = 1; d = io_rdata; end
    end
    io_req = 1'b0;
    ok = seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (!io_ack) seen = 1;
    end
    ok = ok && seen;
    if (ok) last_rd = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if (io_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", io_ack); end
    total++; if (io_rdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 00", io_rdata); end
    total++; if (rd_blocked !== 1'b0) begin bad++; $display("[TB] FAIL reset_blocked: got %b want 0", rd_blocked); end
    total++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_flags: got tx_valid=%b rx_ready=%b want 0/1", tx_valid, rx_ready); end
    total++; if (tx_level !== 5'd0 || rx_level !== 5'd0) begin bad++; $display("[TB] FAIL reset_levels: got %0d/%0d want 0/0", tx_level, rx_level); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    tx_ready = 1'b0;
    io_req = 1'b1; io_dir = DIR_WR; io_wdata = 8'h41;
    step();
    total++; if (io_ack !== 1'b1) begin bad++; $display("[TB] FAIL wr1_ack: got %b want 1", io_ack); end
    total++; if (tx_level !== 5'd1 || tx_valid !== 1'b1) begin bad++; $display("[TB] FAIL wr1_level: got %0d valid=%b want 1/1", tx_level, tx_valid); end
    total++; if (tx_data !== 8'h41) begin bad++; $display("[TB] FAIL wr1_data: got %h want 41", tx_data); end
    io_req = 1'b0;
    step();
    total++; if (io_ack !== 1'b0) begin bad++; $display("[TB] FAIL wr1_ackfall: got %b want 0", io_ack); end
    total++; if (io_rdata !== last_rd) begin bad++; $display("[TB] FAIL wr1_rdata_hold: got %h want %h", io_rdata, last_rd); end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    total++; if (tx_level !== 5'd0 || tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL wr1_drain: got %0d valid=%b want 0/0", tx_level, tx_valid); end
  endtask

  task automatic test_tx_full();
    bit ok;
    bit all_ok = 1;
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_write(8'(i), ok);
      all_ok = all_ok && ok;
    end
    total++; if (!all_ok || tx_level !== 5'd16) begin bad++; $display("[TB] FAIL txfull_fill: got ok=%b level=%0d want 1/16", all_ok, tx_level); end
    io_req = 1'b1; io_dir = DIR_WR; io_wdata = 8'h10;
    step(); step();
    total++; if (io_ack !== 1'b0 || tx_level !== 5'd16) begin bad++; $display("[TB] FAIL txfull_wait: got ack=%b level=%0d want 0/16", io_ack, tx_level); end
    tx_ready = 1'b1;
    total++; if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL txfull_head: got %h want 00", tx_data); end
    step();
    tx_ready = 1'b0;
    total++; if (io_ack !== 1'b0 || tx_level !== 5'd15) begin bad++; $display("[TB] FAIL txfull_sameedge: got ack=%b level=%0d want 0/15", io_ack, tx_level); end
    step();
    total++; if (io_ack !== 1'b1 || tx_level !== 5'd16) begin bad++; $display("[TB] FAIL txfull_push: got ack=%b level=%0d want 1/16", io_ack, tx_level); end
    io_req = 1'b0;
    step();
    total++; if (io_ack !== 1'b0) begin bad++; $display("[TB] FAIL txfull_ackfall: got %b want 0", io_ack); end
    tx_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      total++; if (tx_data !== 8'(i) || tx_valid !== 1'b1) begin bad++; $display("[TB] FAIL txfull_order: got %h valid=%b want %h/1", tx_data, tx_valid, 8'(i)); end
      step();
    end
    tx_ready = 1'b0;
    total++; if (tx_level !== 5'd0) begin bad++; $display("[TB] FAIL txfull_empty: got %0d want 0", tx_level); end
  endtask

  task automatic test_read_blocked();
    io_req = 1'b1; io_dir = DIR_RD;
    step();
    total++; if (rd_blocked !== 1'b1 || io_ack !== 1'b0) begin bad++; $display("[TB] FAIL rdblk_wait: got blk=%b ack=%b want 1/0", rd_blocked, io_ack); end
    rx_valid = 1'b1; rx_data = 8'h7F;
    step();
    rx_valid = 1'b0;
    total++; if (rx_level !== 5'd1 || io_ack !== 1'b0 || rd_blocked !== 1'b1) begin bad++; $display("[TB] FAIL rdblk_fill: got level=%0d ack=%b blk=%b want 1/0/1", rx_level, io_ack, rd_blocked); end
    step();
    total++; if (io_rdata !== 8'h7F || io_ack !== 1'b1) begin bad++; $display("[TB] FAIL rdblk_data: got %h ack=%b want 7f/1", io_rdata, io_ack); end
    total++; if (rd_blocked !== 1'b0 || rx_level !== 5'd0) begin bad++; $display("[TB] FAIL rdblk_clear: got blk=%b level=%0d want 0/0", rd_blocked, rx_level); end
    last_rd = 8'h7F;
    io_req = 1'b0;
    step();
    total++; if (io_ack !== 1'b0) begin bad++; $display("[TB] FAIL rdblk_ackfall: got %b want 0", io_ack); end
  endtask

  task automatic test_rx_order_and_full();
    logic [7:0] q[$];
    logic [7:0] d;
    logic [7:0] b;
    bit ok;
    for (int i = 1; i <= 3; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i);
      step();
    end
    rx_valid = 1'b0;
    total++; if (rx_level !== 5'd3) begin bad++; $display("[TB] FAIL rx3_level: got %0d want 3", rx_level); end
    for (int i = 1; i <= 3; i++) begin
      cpu_read(d, ok);
      total++; if (!ok || d !== 8'(i)) begin bad++; $display("[TB] FAIL rx3_order: got %h ok=%b want %h", d, ok, 8'(i)); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      rx_valid = 1'b1; rx_data = b;
      step();
    end
    total++; if (rx_ready !== 1'b0 || rx_level !== 5'd16) begin bad++; $display("[TB] FAIL rxfull_flags: got ready=%b level=%0d want 0/16", rx_ready, rx_level); end
    rx_data = 8'hEE;
    step();
    rx_valid = 1'b0;
    total++; if (rx_level !== 5'd16) begin bad++; $display("[TB] FAIL rxfull_reject: got %0d want 16", rx_level); end
    while (q.size() > 0) begin
      cpu_read(d, ok);
      total++; if (!ok || d !== q[0]) begin bad++; $display("[TB] FAIL rxfull_order: got %h ok=%b want %h", d, ok, q[0]); end
      void'(q.pop_front());
    end
    total++; if (rx_level !== 5'd0 || rx_ready !== 1'b1) begin bad++; $display("[TB] FAIL rxfull_empty: got level=%0d ready=%b want 0/1", rx_level, rx_ready); end
  endtask

  // Random sink backpressure against a queue model; phase 0 idle, 1 request up, 2 acked.
  task automatic test_tx_stream();
    logic [7:0] m_q[$];
    int sent = 0;
    int got = 0;
    int phase = 0;
    int next_phase;
    int cyc = 0;
    bit r;
    bit can_push;
    tx_ready = 1'b0;
    io_dir = DIR_WR;
    while ((sent < 40 || phase != 0 || m_q.size() > 0) && cyc < 3000) begin
      if (phase == 0 && sent < 40) begin
        io_req = 1'b1; io_wdata = 8'($urandom); phase = 1;
      end else if (phase == 2) begin
        io_req = 1'b0;
      end
      r = (sent < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      tx_ready = r;
      next_phase = phase;
      can_push = (m_q.size() < DEPTH);
      if (r && m_q.size() > 0) begin
        total++; if (tx_data !== m_q[0]) begin bad++; $display("[TB] FAIL stream_data: got %h want %h", tx_data, m_q[0]); end
        void'(m_q.pop_front());
        got++;
      end
      if (phase == 1 && can_push) begin
        m_q.push_back(io_wdata);
        sent++;
        next_phase = 2;
      end else if (phase == 2) begin
        next_phase = 0;
      end
      step();
      phase = next_phase;
      cyc++;
      total++; if (tx_level !== 5'(m_q.size()) || tx_valid !== (m_q.size() != 0)) begin bad++; $display("[TB] FAIL stream_level: got %0d valid=%b want %0d", tx_level, tx_valid, m_q.size()); end
      total++; if (io_ack !== (phase == 2)) begin bad++; $display("[TB] FAIL stream_ack: got %b want %b", io_ack, phase == 2); end
    end
    tx_ready = 1'b0;
    io_req = 1'b0;
    total++; if (got != 40 || cyc >= 3000) begin bad++; $display("[TB] FAIL stream_count: got %0d want 40", got); end
    total++; if (io_rdata !== last_rd) begin bad++; $display("[TB] FAIL stream_rdata_hold: got %h want %h", io_rdata, last_rd); end
  endtask

  task automatic test_reset_in_ack();
    bit ok;
    bit all_ok = 1;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_write(8'(8'hA0 + i), ok);
      all_ok = all_ok && ok;
    end
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1; rx_data = 8'(8'hB0 + i);
      step();
    end
    rx_valid = 1'b0;
    io_req = 1'b1; io_dir = DIR_RD;
    step();
    total++; if (!all_ok || io_ack !== 1'b1 || io_rdata !== 8'hB0) begin bad++; $display("[TB] FAIL rstack_setup: got ok=%b ack=%b rdata=%h want 1/1/b0", all_ok, io_ack, io_rdata); end
    total++; if (tx_level !== 5'd5 || rx_level !== 5'd5) begin bad++; $display("[TB] FAIL rstack_levels_pre: got %0d/%0d want 5/5", tx_level, rx_level); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (io_ack !== 1'b0 || io_rdata !== 8'h00 || rd_blocked !== 1'b0) begin bad++; $display("[TB] FAIL rstack_outs: got ack=%b rdata=%h blk=%b want 0/00/0", io_ack, io_rdata, rd_blocked); end
    total++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || tx_level !== 5'd0 || rx_level !== 5'd0) begin bad++; $display("[TB] FAIL rstack_fifos: got txv=%b rxr=%b lv=%0d/%0d want 0/1/0/0", tx_valid, rx_ready, tx_level, rx_level); end
    last_rd = 8'h00;
    step();
    io_req = 1'b0;
    rst = 1'b0;
    step();
    total++; if (io_ack !== 1'b0) begin bad++; $display("[TB] FAIL rstack_noresume: got %b want 0", io_ack); end
    io_req = 1'b1; io_dir = DIR_WR; io_wdata = 8'h5A;
    step();
    total++; if (io_ack !== 1'b1 || tx_level !== 5'd1 || tx_data !== 8'h5A) begin bad++; $display("[TB] FAIL rstack_idle: got ack=%b level=%0d data=%h want 1/1/5a", io_ack, tx_level, tx_data); end
    io_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tx_full();
    test_read_blocked();
    test_rx_order_and_full();
    test_tx_stream();
    test_reset_in_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
